// File: rtl/sha256_pkg.sv
// sha256_pkg - shared widths, FSM state type and SHA-256 schedule sigma functions.
// Rev 1.0
`default_nettype none

package sha256_pkg;

    localparam int WORD_W    = 32;
    localparam int ROUNDS    = 64;
    localparam int WIN_DEPTH = 16;
    localparam int T_W       = $clog2(ROUNDS);
    localparam int CNT_W     = $clog2(WIN_DEPTH);

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // ROTR7 ^ ROTR18 ^ SHR3
    function automatic word_t sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    // ROTR17 ^ ROTR19 ^ SHR10
    function automatic word_t sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_sigma.sv
// sha256_sigma - combinational schedule sigma; SEL1=0 gives sigma0, SEL1=1 gives sigma1.
// Rev 1.0
`default_nettype none

module sha256_sigma
    import sha256_pkg::*;
#(
    parameter bit SEL1 = 1'b0
) (
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] y
);

    if (SEL1) begin : g_sigma1
        assign y = sigma1(x);
    end else begin : g_sigma0
        assign y = sigma0(x);
    end

endmodule

`default_nettype wire

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched - loads a 16-word block, then streams W0..W63 with a valid/ready handshake.
// Rev 1.0
`default_nettype none

module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [WORD_W-1:0] blk_word_i,
    input  logic              blk_valid_i,
    output logic              blk_ready_o,
    output logic [WORD_W-1:0] w_o,
    output logic              w_valid_o,
    input  logic              w_ready_i,
    output logic [T_W-1:0]    t_o,
    output logic              busy_o,
    output logic              done_o
);

    state_t            state;
    state_t            state_nxt;
    word_t             window [WIN_DEPTH];
    logic [CNT_W-1:0]  word_cnt;
    logic [T_W-1:0]    t;
    word_t             s0;
    word_t             s1;
    word_t             new_word;
    logic              load_fire;
    logic              run_fire;
    logic              last_word;
    logic              last_round;

    assign load_fire  = (state == LOAD) && blk_valid_i;
    assign run_fire   = (state == RUN) && w_ready_i;
    assign last_word  = load_fire && (word_cnt == CNT_W'(WIN_DEPTH - 1));
    assign last_round = run_fire && (t == T_W'(ROUNDS - 1));

    sha256_sigma #(.SEL1(1'b0)) u_sigma0 (.x(window[1]),  .y(s0));
    sha256_sigma #(.SEL1(1'b1)) u_sigma1 (.x(window[14]), .y(s1));

    assign new_word = s1 + window[9] + s0 + window[0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)      state_nxt = LOAD;
            LOAD:    if (last_word)  state_nxt = RUN;
            RUN:     if (last_round) state_nxt = DONE;
            DONE:                    state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Word counter wraps to 0 on the 16th word; t saturates at the last round.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            word_cnt <= '0;
            t        <= '0;
        end else if (state == IDLE && start) begin
            word_cnt <= '0;
            t        <= '0;
        end else if (load_fire) begin
            word_cnt <= word_cnt + 1'b1;
        end else if (run_fire && !last_round) begin
            t <= t + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < WIN_DEPTH; i++) begin
                window[i] <= '0;
            end
        end else if (load_fire || run_fire) begin
            for (int i = 0; i < WIN_DEPTH - 1; i++) begin
                window[i] <= window[i+1];
            end
            window[WIN_DEPTH-1] <= load_fire ? blk_word_i : new_word;
        end
    end

    assign blk_ready_o = (state == LOAD);
    assign w_valid_o   = (state == RUN);
    assign w_o         = w_valid_o ? window[0] : '0;
    assign t_o         = w_valid_o ? t : '0;
    assign busy_o      = (state != IDLE);
    assign done_o      = (state == DONE);

endmodule

`default_nettype wire

// File: doc/sha256_msg_sched.md
SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

Interface
REQ-001 Parameters: none; word width (32) and round count (64) SHALL come from the shared package.
REQ-002 CLK  in  1  clock; all state SHALL update on its rising edge.
REQ-003 RST  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  one-cycle request to begin a new 512-bit block.
REQ-005 blk_word_i  in  32  message block word, big-endian order, word 0 first.
REQ-006 blk_valid_i  in  1  blk_word_i valid.
REQ-007 blk_ready_o  out  1  block accepts a word (LOAD state only).
REQ-008 w_o  out  32  schedule word W_t for the current round.
REQ-009 w_valid_o  out  1  w_o and t_o valid (RUN state only).
REQ-010 w_ready_i  in  1  round datapath consumes W_t this cycle.
REQ-011 t_o  out  6  round index of w_o, 0..63.
REQ-012 busy_o  out  1  high in any state other than IDLE.
REQ-013 done_o  out  1  one-cycle pulse after W63 is consumed.

Function
REQ-014 FSM SHALL have states IDLE, LOAD, RUN, DONE.
REQ-015 IDLE: start=1 -> LOAD next cycle; word counter and t cleared.
REQ-016 start SHALL be ignored in LOAD, RUN and DONE.
REQ-017 LOAD: blk_ready_o=1; each cycle with blk_valid_i=1 shifts blk_word_i into a 16-word window at slot 15, older words move toward slot 0.
REQ-018 Gaps (blk_valid_i=0) in LOAD SHALL hold window and counter unchanged.
REQ-019 After the 16th accepted word -> RUN next cycle, window[0]=W0, t=0.
REQ-020 RUN: w_valid_o=1, w_o=window[0], t_o=t.
REQ-021 While w_valid_o=1 and w_ready_i=0, w_o and t_o SHALL hold stable.
REQ-022 On w_valid_o and w_ready_i: window shifts down one, slot 15 loads sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0], modulo 2^32 (carries discarded), t increments.
REQ-023 sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3; sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
REQ-024 Handshake at t=63 -> DONE next cycle; t SHALL NOT wrap past 63 in RUN.
REQ-025 DONE lasts one cycle with done_o=1, then IDLE; start seen in DONE SHALL be ignored.
REQ-026 Throughput: one W per cycle with w_ready_i held high; first W0 one cycle after the 16th load.
REQ-027 blk_ready_o and w_valid_o SHALL never both be high.

Reset
REQ-028 RST=1 SHALL immediately force IDLE and clear window, counters, w_o, t_o, blk_ready_o, w_valid_o, busy_o and done_o to 0, independent of CLK.
REQ-029 RST mid-LOAD or mid-RUN SHALL discard the partial block; the next block requires a new start.

Structure
REQ-030 Package sha256_pkg SHALL hold WORD_W=32, ROUNDS=64, the FSM state type and the sigma0/sigma1 functions.
REQ-031 Sub-module sha256_sigma (combinational, selectable sigma0/sigma1) SHALL implement the schedule sigma functions.
REQ-032 The window SHALL be a single 16x32 shift register; no memory macro.

Verification
REQ-033 "abc" block (word0=0x61626380, words1-14=0, word15=0x00000018), w_ready_i=1 -> W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000, 64 handshakes, done_o pulse one cycle after t=63.
REQ-034 Same block, w_ready_i toggled randomly -> identical W sequence, w_o/t_o stable across every stall, exactly 64 transfers.
REQ-035 blk_valid_i with 3-cycle gaps during LOAD -> RUN entered only after 16 accepted words, W sequence unchanged vs REQ-033.
REQ-036 start pulsed at t=20 in RUN -> ignored, block completes normally, done_o at end.
REQ-037 RST asserted at t=30, released, then new start and "abc" block -> all outputs 0 during reset, fresh run reproduces REQ-033 values.
REQ-038 Two blocks back-to-back (start in cycle after done_o) -> second run t_o restarts at 0, no residual window data.
